// File: rtl/beta_mc.sv
// beta_mc: multicycle Beta core with req/ack instruction and data ports.
// FETCH -> EXEC -> (MEM) -> FETCH; illegal opcodes park the core in HALT.
module beta_mc #(
  parameter int XLEN = 32,
  parameter int AW = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            RESET,
  output logic            imem_req,
  output logic [AW-1:0]   imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [AW-1:0]   dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [AW-1:0]   pc,
  output logic            retire,
  output logic            halted
);

  localparam int SW = $clog2(XLEN);
  localparam logic [15:0] FN_OK = 16'b0111_0111_0111_0011;

  typedef enum logic [1:0] {
    S_FETCH, S_EXEC, S_MEM, S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic            imem_req_q, imem_req_d;
  logic            dmem_req_q, dmem_req_d;
  logic            dmem_we_q, dmem_we_d;
  logic [AW-1:0]   dmem_addr_q, dmem_addr_d;
  logic [XLEN-1:0] dmem_wdata_q, dmem_wdata_d;
  logic [XLEN-1:0] regs_q [32];

  logic            rf_we;
  logic [XLEN-1:0] rf_wd;

  logic [5:0]  opcode;
  logic [3:0]  fn;
  logic [4:0]  rc, ra, rb, rb_addr;
  logic [15:0] lit;
  logic        is_alu, is_mem, is_st, is_jmp, is_br;

  logic signed [XLEN-1:0] sxt;
  logic [XLEN-1:0] ra_v, rb_v, opb, alu_y, ea, link;
  logic [SW-1:0]   sh;
  logic [AW-1:0]   pc_inc, br_tgt;
  logic            take;

  assign opcode = ir_q[31:26];
  assign fn     = opcode[3:0];
  assign rc     = ir_q[25:21];
  assign ra     = ir_q[20:16];
  assign rb     = ir_q[15:11];
  assign lit    = ir_q[15:0];

  assign is_alu = opcode[5] && FN_OK[fn];
  assign is_st  = opcode == 6'h19;
  assign is_mem = opcode == 6'h18 || is_st;
  assign is_jmp = opcode == 6'h1B;
  assign is_br  = opcode == 6'h1C || opcode == 6'h1D;

  // Stores read Rc through the second port in place of Rb.
  assign rb_addr = is_st ? rc : rb;
  assign ra_v = (ra == 5'd31) ? '0 : regs_q[ra];
  assign rb_v = (rb_addr == 5'd31) ? '0 : regs_q[rb_addr];

  assign sxt    = XLEN'($signed(lit));
  assign opb    = opcode[4] ? sxt : rb_v;
  assign sh     = opb[SW-1:0];
  assign ea     = ra_v + sxt;
  assign pc_inc = pc_q + AW'(1);
  assign br_tgt = pc_inc + AW'(sxt);
  assign link   = XLEN'(pc_inc);
  assign take   = (ra_v == '0) ^ opcode[0];

  // ALU result for OP/OPC, selected by the low opcode nibble.
  always_comb begin
    alu_y = '0;
    case (fn)
      4'h0: alu_y = ra_v + opb;
      4'h1: alu_y = ra_v - opb;
      4'h4: alu_y = XLEN'(ra_v == opb);
      4'h5: alu_y = XLEN'($signed(ra_v) < $signed(opb));
      4'h6: alu_y = XLEN'($signed(ra_v) <= $signed(opb));
      4'h8: alu_y = ra_v & opb;
      4'h9: alu_y = ra_v | opb;
      4'hA: alu_y = ra_v ^ opb;
      4'hC: alu_y = ra_v << sh;
      4'hD: alu_y = ra_v >> sh;
      4'hE: alu_y = $signed(ra_v) >>> sh;
      default: alu_y = '0;
    endcase
  end

  // Next state, port requests, writeback and retire.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    imem_req_d   = imem_req_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    rf_we        = 1'b0;
    rf_wd        = alu_y;
    retire       = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req_d = 1'b1;
        if (imem_req_q && imem_ack) begin
          ir_d       = imem_rdata;
          imem_req_d = 1'b0;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d    = S_FETCH;
        imem_req_d = 1'b1;
        unique case (1'b1)
          is_alu: begin
            rf_we  = 1'b1;
            pc_d   = pc_inc;
            retire = 1'b1;
          end
          is_mem: begin
            imem_req_d   = 1'b0;
            dmem_req_d   = 1'b1;
            dmem_we_d    = is_st;
            dmem_addr_d  = AW'(ea);
            dmem_wdata_d = rb_v;
            state_d      = S_MEM;
          end
          is_jmp: begin
            rf_we  = 1'b1;
            rf_wd  = link;
            pc_d   = AW'(ra_v);
            retire = 1'b1;
          end
          is_br: begin
            rf_we  = 1'b1;
            rf_wd  = link;
            pc_d   = take ? br_tgt : pc_inc;
            retire = 1'b1;
          end
          default: begin
            imem_req_d = 1'b0;
            state_d    = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_req_q && dmem_ack) begin
          dmem_req_d = 1'b0;
          rf_we      = !dmem_we_q;
          rf_wd      = dmem_rdata;
          pc_d       = pc_inc;
          retire     = 1'b1;
          imem_req_d = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_HALT: begin
        imem_req_d = 1'b0;
      end
    endcase
  end

  // Control and port registers.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
    end
  end

  // Register file; R31 is never written.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (rf_we && rc != 5'd31) begin
      regs_q[rc] <= rf_wd;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign pc         = pc_q;
  assign halted     = state_q == S_HALT;

endmodule

// File: tb/tb_beta_mc.sv
// tb_beta_mc: directed programs against beta_mc with queue scoreboard.
// Retire PCs and data-port transactions are checked by a monitor.
module tb_beta_mc;

  logic        clk;
  logic        RESET;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] pc;
  logic        retire, halted;

  beta_mc dut (
    .clk(clk), .RESET(RESET),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .retire(retire), .halted(halted)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          chk_wd;
  } mexp_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ilat = 0;
  int dlat = 0;
  int icnt = 0;
  int dcnt = 0;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  logic [31:0] ret_q [$];
  mexp_t       mem_q [$];
  int          ret_cyc [$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op,
      input logic [4:0] rc, input logic [4:0] ra,
      input logic [15:0] lit);
    return {op, rc, ra, lit};
  endfunction

  function automatic logic [31:0] encr(input logic [5:0] op,
      input logic [4:0] rc, input logic [4:0] ra,
      input logic [4:0] rb);
    return {op, rc, ra, rb, 11'b0};
  endfunction

  // Memories: ack after ilat/dlat wait cycles, driven just after the edge.
  initial begin
    imem_ack = 0; dmem_ack = 0;
    imem_rdata = '0; dmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!RESET) begin
        icnt = 0; dcnt = 0;
        imem_ack = 0; dmem_ack = 0;
      end else begin
        if (imem_ack) icnt = 0;
        if (dmem_ack) dcnt = 0;
        imem_ack = 0;
        dmem_ack = 0;
        if (imem_req) begin
          if (icnt >= ilat) begin
            imem_ack = 1;
            imem_rdata = imem[imem_addr[7:0]];
          end else icnt++;
        end
        if (dmem_req) begin
          if (dcnt >= dlat) begin
            dmem_ack = 1;
            if (dmem_we) dmem[dmem_addr[7:0]] = dmem_wdata;
            else dmem_rdata = dmem[dmem_addr[7:0]];
          end else dcnt++;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT retires or accesses data.
  always @(negedge clk) begin : mon
    mexp_t m;
    logic [31:0] e;
    if (RESET) begin
      cyc++;
      if (imem_req && dmem_req) check("req_overlap", 1, 0);
      if (retire) begin
        ret_cyc.push_back(cyc);
        if (ret_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL retire_unexpected: got pc %h want none", pc);
        end else begin
          e = ret_q.pop_front();
          check("retire_pc", pc, e);
        end
      end
      if (dmem_req) begin
        if (mem_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL dmem_unexpected: got addr %h want none",
                   dmem_addr);
        end else begin
          m = mem_q[0];
          check("dmem_we", dmem_we, m.we);
          check("dmem_addr", dmem_addr, m.addr);
          if (m.chk_wd) check("dmem_wdata", dmem_wdata, m.wd);
          if (dmem_ack) void'(mem_q.pop_front());
        end
      end
    end
  end

  task automatic push_mem(input logic we, input logic [31:0] a,
                          input logic [31:0] wd);
    mexp_t m;
    m.we = we; m.addr = a; m.wd = wd; m.chk_wd = we;
    mem_q.push_back(m);
  endtask

  task automatic push_ret(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) ret_q.push_back(32'(i));
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    RESET = 0; #1;
    check("rst_imem_req", imem_req, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_dmem_we", dmem_we, 0);
    check("rst_dmem_addr", dmem_addr, 0);
    check("rst_dmem_wdata", dmem_wdata, 0);
    check("rst_pc", pc, 0);
    check("rst_retire", retire, 0);
    check("rst_halted", halted, 0);
    ret_q.delete(); mem_q.delete(); ret_cyc.delete();
    for (int i = 0; i < 256; i++) begin
      imem[i] = '0; dmem[i] = '0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic release_first_fetch();
    RESET = 1;
    @(negedge clk);
    check("first_imem_req", imem_req, 1);
    check("first_imem_addr", imem_addr, 0);
  endtask

  task automatic wait_halt(input int max, input logic [31:0] hpc);
    for (int i = 0; i < max && !halted; i++) @(negedge clk);
    check("halt_reached", halted, 1);
    check("halt_pc", pc, hpc);
    repeat (4) begin
      @(negedge clk);
      check("halt_no_req", {imem_req, dmem_req}, 0);
    end
    check("ret_q_drained", ret_q.size(), 0);
    check("mem_q_drained", mem_q.size(), 0);
  endtask

  initial begin
    RESET = 0;
    // Program A: ALU chain, load/store with waits, ALU edges, MUL halt.
    do_reset();
    ilat = 0; dlat = 3;
    imem[0]  = enc(6'h30, 1, 31, 16'd5);
    imem[1]  = enc(6'h30, 2, 1, 16'hFFFD);
    imem[2]  = enc(6'h19, 2, 31, 16'h10);
    imem[3]  = enc(6'h18, 3, 31, 16'h10);
    imem[4]  = enc(6'h19, 3, 31, 16'h11);
    imem[5]  = enc(6'h30, 6, 31, 16'd1);
    imem[6]  = encr(6'h21, 5, 31, 6);
    imem[7]  = enc(6'h19, 5, 31, 16'h12);
    imem[8]  = enc(6'h3C, 7, 6, 16'd31);
    imem[9]  = encr(6'h25, 8, 7, 6);
    imem[10] = enc(6'h19, 8, 31, 16'h13);
    imem[11] = enc(6'h3E, 9, 7, 16'd31);
    imem[12] = enc(6'h19, 9, 31, 16'h14);
    imem[13] = enc(6'h30, 10, 31, 16'd33);
    imem[14] = encr(6'h2C, 11, 6, 10);
    imem[15] = enc(6'h19, 11, 31, 16'h15);
    imem[16] = enc(6'h30, 31, 31, 16'd7);
    imem[17] = enc(6'h19, 31, 31, 16'h16);
    imem[18] = encr(6'h2A, 12, 5, 6);
    imem[19] = enc(6'h19, 12, 31, 16'h17);
    imem[20] = encr(6'h22, 1, 2, 3);
    push_ret(0, 19);
    push_mem(1, 32'h10, 32'd2);
    push_mem(0, 32'h10, 32'd0);
    push_mem(1, 32'h11, 32'd2);
    push_mem(1, 32'h12, 32'hFFFF_FFFF);
    push_mem(1, 32'h13, 32'd1);
    push_mem(1, 32'h14, 32'hFFFF_FFFF);
    push_mem(1, 32'h15, 32'd2);
    push_mem(1, 32'h16, 32'd0);
    push_mem(1, 32'h17, 32'hFFFF_FFFE);
    release_first_fetch();
    wait_halt(400, 32'd20);
    if (ret_cyc.size() >= 3) begin
      check("alu_cadence", 32'(ret_cyc[1] - ret_cyc[0]), 2);
      check("st_latency", 32'(ret_cyc[2] - ret_cyc[1]), 6);
    end else check("retire_count", ret_cyc.size(), 20);

    // Program B: branches and jump with waits on both ports.
    do_reset();
    check("reset_clears_halt", halted, 0);
    ilat = 1; dlat = 2;
    imem[0] = enc(6'h30, 1, 31, 16'd0);
    imem[1] = enc(6'h30, 4, 31, 16'h40);
    for (int i = 2; i < 8; i++) imem[i] = enc(6'h30, 31, 31, 16'd0);
    imem[8]  = enc(6'h1C, 13, 1, 16'd3);
    imem[12] = enc(6'h19, 13, 31, 16'h20);
    imem[13] = enc(6'h1D, 14, 1, 16'd3);
    imem[14] = enc(6'h19, 14, 31, 16'h21);
    imem[15] = enc(6'h1B, 15, 4, 16'd0);
    imem[8'h40] = enc(6'h19, 15, 31, 16'h22);
    imem[8'h41] = enc(6'h1D, 16, 4, 16'd2);
    imem[8'h44] = enc(6'h19, 16, 31, 16'h23);
    push_ret(0, 8);
    push_ret(12, 15);
    push_ret(32'h40, 32'h41);
    push_ret(32'h44, 32'h44);
    push_mem(1, 32'h20, 32'd9);
    push_mem(1, 32'h21, 32'd14);
    push_mem(1, 32'h22, 32'd16);
    push_mem(1, 32'h23, 32'h42);
    release_first_fetch();
    wait_halt(400, 32'h45);

    // Program C: asynchronous reset while a store waits for its ack.
    do_reset();
    ilat = 0; dlat = 20;
    imem[0] = enc(6'h19, 31, 31, 16'h30);
    push_mem(1, 32'h30, 32'd0);
    release_first_fetch();
    for (int i = 0; i < 20 && !dmem_req; i++) @(negedge clk);
    check("c_dmem_req_up", dmem_req, 1);
    repeat (2) @(negedge clk);
    #1;
    RESET = 0;
    #1;
    check("async_dmem_req", dmem_req, 0);
    check("async_pc", pc, 0);
    mem_q.delete();
    repeat (2) @(negedge clk);
    dlat = 0;
    push_ret(0, 0);
    push_mem(1, 32'h30, 32'd0);
    release_first_fetch();
    wait_halt(100, 32'd1);
    check("c_store_data", dmem[8'h30], 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
